// File: rtl/vga_timing_cfg.sv
// Double-buffered VGA timing configuration bank: presets or custom set, applied at frame boundary.
// Optional commit sanity check enabled by defining VGA_CFG_CHECK_EN.
module vga_timing_cfg #(
    parameter int unsigned CONFIG_WIDTH  = 16,
    parameter int unsigned BASE_ADDR     = 16'h0010,
    parameter int unsigned PORCH_WIDTH   = 8,
    parameter int unsigned REZ_WIDTH     = 11,
    parameter int unsigned REZ_MAX_WIDTH = 11,
    parameter bit          IMMEDIATE     = 1'b0
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Valid,
    input  logic [CONFIG_WIDTH-1:0]  Addr,
    input  logic [CONFIG_WIDTH-1:0]  Data,
    input  logic                     Frame_end,
    output logic                     Load_config,
    output logic                     Pending,
    output logic                     Cfg_err,
    output logic [PORCH_WIDTH-1:0]   H_front_porch,
    output logic [PORCH_WIDTH-1:0]   H_back_porch,
    output logic [PORCH_WIDTH-1:0]   V_front_porch,
    output logic [PORCH_WIDTH-1:0]   V_back_porch,
    output logic [REZ_WIDTH-1:0]     H_count_activ,
    output logic [REZ_WIDTH-1:0]     V_count_activ,
    output logic [REZ_MAX_WIDTH-1:0] H_count_max,
    output logic [REZ_MAX_WIDTH-1:0] V_count_max
);
    localparam int unsigned SUM_W    = REZ_MAX_WIDTH + 1;
    localparam int unsigned NUM_REGS = 9;

    typedef struct packed {
        logic [PORCH_WIDTH-1:0]   h_fp;
        logic [PORCH_WIDTH-1:0]   h_bp;
        logic [PORCH_WIDTH-1:0]   v_fp;
        logic [PORCH_WIDTH-1:0]   v_bp;
        logic [REZ_WIDTH-1:0]     h_act;
        logic [REZ_WIDTH-1:0]     v_act;
        logic [REZ_MAX_WIDTH-1:0] h_max;
        logic [REZ_MAX_WIDTH-1:0] v_max;
    } timing_t;

    typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

    function automatic timing_t mk_timing(input int unsigned hfp, input int unsigned hbp,
                                          input int unsigned vfp, input int unsigned vbp,
                                          input int unsigned hact, input int unsigned vact,
                                          input int unsigned hmax, input int unsigned vmax);
        timing_t t;
        t.h_fp  = PORCH_WIDTH'(hfp);
        t.h_bp  = PORCH_WIDTH'(hbp);
        t.v_fp  = PORCH_WIDTH'(vfp);
        t.v_bp  = PORCH_WIDTH'(vbp);
        t.h_act = REZ_WIDTH'(hact);
        t.v_act = REZ_WIDTH'(vact);
        t.h_max = REZ_MAX_WIDTH'(hmax);
        t.v_max = REZ_MAX_WIDTH'(vmax);
        return t;
    endfunction

    localparam timing_t MODE_640  = mk_timing(16, 48, 10, 33, 640, 480, 800, 525);
    localparam timing_t MODE_800  = mk_timing(40, 88, 1, 23, 800, 600, 1056, 628);
    localparam timing_t MODE_1024 = mk_timing(24, 160, 3, 29, 1024, 768, 1344, 806);

    timing_t staging_q, staging_d;
    timing_t shadow_q,  shadow_d;
    timing_t active_q,  active_d;
    state_t  state_q,   state_d;
    logic    load_q,    load_d;
    logic    pending_q, pending_d;
    logic    err_q,     err_d;

    logic [CONFIG_WIDTH-1:0] offset_c;
    logic                    wr_c;
    logic                    mode_wr_c;
    logic                    custom_c;
    logic                    commit_c;
    logic                    cfg_bad_c;
    timing_t                 sel_c;

    // Unsigned wrap makes addresses below the window fall out of range too
    assign offset_c  = Addr - CONFIG_WIDTH'(BASE_ADDR);
    assign wr_c      = Valid && (offset_c < CONFIG_WIDTH'(NUM_REGS));
    assign mode_wr_c = wr_c && (offset_c == '0) && (Data <= CONFIG_WIDTH'(3));
    assign custom_c  = (Data[1:0] == 2'd3);
    assign commit_c  = mode_wr_c && !(custom_c && cfg_bad_c);

`ifdef VGA_CFG_CHECK_EN
    logic [SUM_W-1:0] h_sum_c;
    logic [SUM_W-1:0] v_sum_c;
    assign h_sum_c = SUM_W'(staging_q.h_act) + SUM_W'(staging_q.h_fp) + SUM_W'(staging_q.h_bp);
    assign v_sum_c = SUM_W'(staging_q.v_act) + SUM_W'(staging_q.v_fp) + SUM_W'(staging_q.v_bp);
    assign cfg_bad_c = (staging_q.h_act == '0) || (staging_q.v_act == '0) ||
                       (h_sum_c >= SUM_W'(staging_q.h_max)) ||
                       (v_sum_c >= SUM_W'(staging_q.v_max));
`else
    assign cfg_bad_c = 1'b0;
`endif

    always_comb begin
        case (Data[1:0])
            2'd0:    sel_c = MODE_640;
            2'd1:    sel_c = MODE_800;
            2'd2:    sel_c = MODE_1024;
            default: sel_c = staging_q;
        endcase
    end

    // Staging writes, commit handling and frame-boundary apply
    always_comb begin
        staging_d = staging_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        state_d   = state_q;
        load_d    = 1'b0;
        err_d     = mode_wr_c && custom_c && cfg_bad_c;

        if (wr_c) begin
            case (offset_c[3:0])
                4'd1:    staging_d.h_fp  = PORCH_WIDTH'(Data);
                4'd2:    staging_d.h_bp  = PORCH_WIDTH'(Data);
                4'd3:    staging_d.v_fp  = PORCH_WIDTH'(Data);
                4'd4:    staging_d.v_bp  = PORCH_WIDTH'(Data);
                4'd5:    staging_d.h_act = REZ_WIDTH'(Data);
                4'd6:    staging_d.v_act = REZ_WIDTH'(Data);
                4'd7:    staging_d.h_max = REZ_MAX_WIDTH'(Data);
                4'd8:    staging_d.v_max = REZ_MAX_WIDTH'(Data);
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (commit_c) state_d = PENDING;
            end
            PENDING: begin
                if (Frame_end || IMMEDIATE) begin
                    active_d = shadow_q;
                    load_d   = 1'b1;
                    state_d  = APPLY;
                end
                if (commit_c) state_d = PENDING;
            end
            APPLY: begin
                state_d = commit_c ? PENDING : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (commit_c) shadow_d = sel_c;
        pending_d = (state_d == PENDING);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            staging_q <= MODE_640;
            shadow_q  <= MODE_640;
            active_q  <= MODE_640;
            state_q   <= IDLE;
            load_q    <= 1'b0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            staging_q <= staging_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            state_q   <= state_d;
            load_q    <= load_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign Load_config   = load_q;
    assign Pending       = pending_q;
    assign Cfg_err       = err_q;
    assign H_front_porch = active_q.h_fp;
    assign H_back_porch  = active_q.h_bp;
    assign V_front_porch = active_q.v_fp;
    assign V_back_porch  = active_q.v_bp;
    assign H_count_activ = active_q.h_act;
    assign V_count_activ = active_q.v_act;
    assign H_count_max   = active_q.h_max;
    assign V_count_max   = active_q.v_max;

endmodule
